// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter giving NUM_LSUS load/store units one shared data-memory port, one transaction at a time.
// Latency: grant in cycle 0, memory request from cycle 1, response pass-through from cycle 2, re-arbitration in cycle 3.
// Backpressure: a stalled memory request or response channel holds the FSM; latched request fields stay stable.
module lsu_mem_arbiter #(
  parameter int NUM_LSUS        = 4,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_LSUS-1:0]                  lsu_read_req_val,
  input  logic [NUM_LSUS*DATA_ADDR_WIDTH-1:0]  lsu_read_req_addr,
  output logic [NUM_LSUS-1:0]                  lsu_read_req_rdy,
  output logic [NUM_LSUS-1:0]                  lsu_read_resp_val,
  output logic [DATA_WIDTH-1:0]                lsu_read_resp_data,
  input  logic [NUM_LSUS-1:0]                  lsu_read_resp_rdy,
  input  logic [NUM_LSUS-1:0]                  lsu_write_req_val,
  input  logic [NUM_LSUS*DATA_ADDR_WIDTH-1:0]  lsu_write_req_addr,
  input  logic [NUM_LSUS*DATA_WIDTH-1:0]       lsu_write_req_data,
  output logic [NUM_LSUS-1:0]                  lsu_write_req_rdy,
  output logic [NUM_LSUS-1:0]                  lsu_write_resp_val,
  output logic                                 mem_read_req_val,
  output logic [DATA_ADDR_WIDTH-1:0]           mem_read_req_addr,
  input  logic                                 mem_read_req_rdy,
  input  logic                                 mem_read_resp_val,
  input  logic [DATA_WIDTH-1:0]                mem_read_resp_data,
  output logic                                 mem_read_resp_rdy,
  output logic                                 mem_write_req_val,
  output logic [DATA_ADDR_WIDTH-1:0]           mem_write_req_addr,
  output logic [DATA_WIDTH-1:0]                mem_write_req_data,
  input  logic                                 mem_write_req_rdy,
  input  logic                                 mem_write_resp_val,
  output logic                                 busy,
  output logic [$clog2(NUM_LSUS)-1:0]          grant_id
);

  localparam int GW = $clog2(NUM_LSUS);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_WAIT,
    WRITE_REQ,
    WRITE_WAIT
  } state_t;

  state_t                     state;
  logic [GW-1:0]              rr_ptr;
  logic [GW-1:0]              win;
  logic                       found;
  logic [NUM_LSUS-1:0]        req;
  logic [GW-1:0]              nxt_ptr;
  logic [31:0]                idx;
  logic [DATA_ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]      lat_data;

  assign req     = lsu_read_req_val | lsu_write_req_val;
  assign nxt_ptr = (grant_id == GW'(NUM_LSUS - 1)) ? '0 : grant_id + 1'b1;

  // Both memory request channels carry the single latched address; only one valid is ever high.
  assign mem_read_req_addr  = lat_addr;
  assign mem_write_req_addr = lat_addr;
  assign mem_write_req_data = lat_data;

  // Pick the first requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_LSUS; k++) begin
      idx = 32'(rr_ptr) + 32'(k);
      if (idx >= 32'(NUM_LSUS)) idx = idx - 32'(NUM_LSUS);
      if (!found && req[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  // Accept strobe for the winner only; a read beats a write from the same LSU.
  always_comb begin
    lsu_read_req_rdy  = '0;
    lsu_write_req_rdy = '0;
    if (reset && state == IDLE && found) begin
      if (lsu_read_req_val[win]) lsu_read_req_rdy[win]  = 1'b1;
      else                       lsu_write_req_rdy[win] = 1'b1;
    end
  end

  // Route memory responses to the granted LSU only while waiting for them.
  always_comb begin
    lsu_read_resp_val  = '0;
    lsu_write_resp_val = '0;
    lsu_read_resp_data = '0;
    mem_read_resp_rdy  = 1'b0;
    if (state == READ_WAIT) begin
      lsu_read_resp_val[grant_id] = mem_read_resp_val;
      lsu_read_resp_data          = mem_read_resp_data;
      mem_read_resp_rdy           = lsu_read_resp_rdy[grant_id];
    end
    if (state == WRITE_WAIT) begin
      lsu_write_resp_val[grant_id] = mem_write_resp_val;
    end
  end

  // Transaction FSM with registered memory-request, busy and grant outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      busy              <= 1'b0;
      mem_read_req_val  <= 1'b0;
      mem_write_req_val <= 1'b0;
      lat_addr          <= '0;
      lat_data          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= win;
            busy     <= 1'b1;
            if (lsu_read_req_val[win]) begin
              lat_addr         <= lsu_read_req_addr[win*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
              mem_read_req_val <= 1'b1;
              state            <= READ_REQ;
            end else begin
              lat_addr          <= lsu_write_req_addr[win*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
              lat_data          <= lsu_write_req_data[win*DATA_WIDTH +: DATA_WIDTH];
              mem_write_req_val <= 1'b1;
              state             <= WRITE_REQ;
            end
          end
        end
        READ_REQ: begin
          if (mem_read_req_rdy) begin
            mem_read_req_val <= 1'b0;
            state            <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (mem_read_resp_val && lsu_read_resp_rdy[grant_id]) begin
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        WRITE_REQ: begin
          if (mem_write_req_rdy) begin
            mem_write_req_val <= 1'b0;
            state             <= WRITE_WAIT;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_resp_val) begin
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: memory model plus a request/response scoreboard, and one task per scenario.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// The memory model answers one cycle after accepting a request unless a scenario takes control of it.
module tb_lsu_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    lsu_read_req_val, lsu_read_req_rdy, lsu_read_resp_val, lsu_read_resp_rdy;
  logic [N*AW-1:0] lsu_read_req_addr, lsu_write_req_addr;
  logic [DW-1:0]   lsu_read_resp_data;
  logic [N-1:0]    lsu_write_req_val, lsu_write_req_rdy, lsu_write_resp_val;
  logic [N*DW-1:0] lsu_write_req_data;
  logic            mem_read_req_val, mem_read_req_rdy, mem_read_resp_val, mem_read_resp_rdy;
  logic [AW-1:0]   mem_read_req_addr, mem_write_req_addr;
  logic [DW-1:0]   mem_read_resp_data, mem_write_req_data;
  logic            mem_write_req_val, mem_write_req_rdy, mem_write_resp_val;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;
  bit auto_rresp = 1'b1;
  logic [DW-1:0] mem_arr [0:255];

  typedef struct {
    int            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;
  txn_t req_q[$];
  txn_t resp_q[$];

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.NUM_LSUS(N), .DATA_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .lsu_read_req_val(lsu_read_req_val), .lsu_read_req_addr(lsu_read_req_addr),
    .lsu_read_req_rdy(lsu_read_req_rdy), .lsu_read_resp_val(lsu_read_resp_val),
    .lsu_read_resp_data(lsu_read_resp_data), .lsu_read_resp_rdy(lsu_read_resp_rdy),
    .lsu_write_req_val(lsu_write_req_val), .lsu_write_req_addr(lsu_write_req_addr),
    .lsu_write_req_data(lsu_write_req_data), .lsu_write_req_rdy(lsu_write_req_rdy),
    .lsu_write_resp_val(lsu_write_resp_val),
    .mem_read_req_val(mem_read_req_val), .mem_read_req_addr(mem_read_req_addr),
    .mem_read_req_rdy(mem_read_req_rdy), .mem_read_resp_val(mem_read_resp_val),
    .mem_read_resp_data(mem_read_resp_data), .mem_read_resp_rdy(mem_read_resp_rdy),
    .mem_write_req_val(mem_write_req_val), .mem_write_req_addr(mem_write_req_addr),
    .mem_write_req_data(mem_write_req_data), .mem_write_req_rdy(mem_write_req_rdy),
    .mem_write_resp_val(mem_write_resp_val),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory: responds the cycle after a request handshake; stores writes.
  task automatic mem_model;
    logic rd_hs, wr_hs, rr_done, rst;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    forever begin
      @(posedge clk);
      rd_hs   = mem_read_req_val && mem_read_req_rdy;
      wr_hs   = mem_write_req_val && mem_write_req_rdy;
      rr_done = mem_read_resp_val && mem_read_resp_rdy;
      rst     = !reset;
      ra = mem_read_req_addr; wa = mem_write_req_addr; wd = mem_write_req_data;
      #1;
      if (rst) begin
        if (auto_rresp) mem_read_resp_val = 1'b0;
        mem_write_resp_val = 1'b0;
      end else begin
        if (auto_rresp) begin
          if (rd_hs) begin
            mem_read_resp_val  = 1'b1;
            mem_read_resp_data = mem_arr[ra];
          end else if (rr_done) begin
            mem_read_resp_val = 1'b0;
          end
        end
        mem_write_resp_val = wr_hs;
        if (wr_hs) mem_arr[wa] = wd;
      end
    end
  endtask

  // Scoreboard: push on LSU accept, match on memory request, match again on response.
  task automatic monitor;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        req_q.delete();
        resp_q.delete();
      end else begin
        checks++;
        if (!$onehot0(lsu_read_req_rdy | lsu_write_req_rdy) || (lsu_read_req_rdy & lsu_write_req_rdy) != '0 ||
            !$onehot0(lsu_read_resp_val) || !$onehot0(lsu_write_resp_val)) begin
          errors++;
          $display("FAIL onehot: rrdy=%b wrdy=%b rval=%b wval=%b, required at most one bit each",
                   lsu_read_req_rdy, lsu_write_req_rdy, lsu_read_resp_val, lsu_write_resp_val);
        end
        for (int i = 0; i < N; i++) begin
          if (lsu_read_req_rdy[i] && lsu_read_req_val[i]) begin
            t.id = i; t.wr = 1'b0; t.addr = lsu_read_req_addr[i*AW +: AW]; t.data = mem_arr[t.addr];
            req_q.push_back(t);
          end else if (lsu_write_req_rdy[i] && lsu_write_req_val[i]) begin
            t.id = i; t.wr = 1'b1; t.addr = lsu_write_req_addr[i*AW +: AW]; t.data = lsu_write_req_data[i*DW +: DW];
            req_q.push_back(t);
          end
        end
        if ((mem_read_req_val && mem_read_req_rdy) || (mem_write_req_val && mem_write_req_rdy)) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL sb_mem_req: memory request with no accepted LSU request");
          end else begin
            t = req_q.pop_front();
            if (mem_write_req_val !== t.wr || mem_read_req_val === t.wr || grant_id !== 2'(t.id) ||
                (t.wr ? (mem_write_req_addr !== t.addr || mem_write_req_data !== t.data)
                      : (mem_read_req_addr !== t.addr))) begin
              errors++;
              $display("FAIL sb_mem_req: got rv=%b wv=%b g=%0d ra=%h wa=%h wd=%h, required wr=%b g=%0d addr=%h data=%h",
                       mem_read_req_val, mem_write_req_val, grant_id, mem_read_req_addr, mem_write_req_addr,
                       mem_write_req_data, t.wr, t.id, t.addr, t.data);
            end
            resp_q.push_back(t);
          end
        end
        if ((mem_read_resp_val && mem_read_resp_rdy) || mem_write_resp_val) begin
          checks++;
          if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_resp: memory response with no outstanding transaction");
          end else begin
            t = resp_q.pop_front();
            if (t.wr ? (lsu_write_resp_val !== 4'(1 << t.id))
                     : (lsu_read_resp_val !== 4'(1 << t.id) || lsu_read_resp_data !== t.data)) begin
              errors++;
              $display("FAIL sb_resp: got rval=%b wval=%b data=%h, required lsu %0d wr=%b data=%h",
                       lsu_read_resp_val, lsu_write_resp_val, lsu_read_resp_data, t.id, t.wr, t.data);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 50 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, grant_id, mem_read_req_val, mem_write_req_val, mem_read_resp_rdy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b g=%0d rv=%b wv=%b rrdy=%b, required all 0",
               busy, grant_id, mem_read_req_val, mem_write_req_val, mem_read_resp_rdy);
    end
    checks++;
    if ({lsu_read_req_rdy, lsu_write_req_rdy, lsu_read_resp_val, lsu_write_resp_val} !== 16'b0 ||
        mem_read_req_addr !== 8'h0 || mem_write_req_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs: rdy=%b/%b resp=%b/%b addr=%h data=%h, required all 0",
               lsu_read_req_rdy, lsu_write_req_rdy, lsu_read_resp_val, lsu_write_resp_val,
               mem_read_req_addr, mem_write_req_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_read;
    mem_arr[8'h3C] = 16'hBEEF;
    @(posedge clk); #1;
    lsu_read_req_addr[1*AW +: AW] = 8'h3C;
    lsu_read_req_val = 4'b0010;
    @(negedge clk);
    checks++;
    if (lsu_read_req_rdy !== 4'b0010 || lsu_write_req_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL single_accept: rrdy=%b wrdy=%b, required 0010 0000", lsu_read_req_rdy, lsu_write_req_rdy);
    end
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    @(negedge clk);
    checks++;
    if ({mem_read_req_val, busy} !== 2'b11 || mem_read_req_addr !== 8'h3C || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL single_req: rv=%b busy=%b addr=%h g=%0d, required 1 1 3c 1",
               mem_read_req_val, busy, mem_read_req_addr, grant_id);
    end
    @(negedge clk);
    checks++;
    if (lsu_read_resp_val !== 4'b0010 || lsu_read_resp_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_resp: val=%b data=%h, required 0010 beef", lsu_read_resp_val, lsu_read_resp_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL single_done: busy=%b g=%0d, required 0 1", busy, grant_id);
    end
    // rr_ptr should now be 2: LSU2 must beat LSU0.
    @(posedge clk); #1;
    lsu_read_req_val = 4'b0101;
    @(negedge clk);
    checks++;
    if (lsu_read_req_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL single_rr_ptr: rrdy=%b, required 0100", lsu_read_req_rdy);
    end
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    wait_idle();
  endtask

  task automatic test_fairness;
    int got[$];
    int cyc[$];
    int n = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    lsu_read_req_val = '1;
    for (int i = 0; i < N; i++) lsu_read_req_addr[i*AW +: AW] = 8'(8'h40 + i);
    @(posedge clk); #1;
    reset = 1'b1;
    while (got.size() < 5 && n < 60) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++) begin
        if (lsu_read_req_rdy[i]) begin
          got.push_back(i);
          cyc.push_back(n);
        end
      end
    end
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL fair_count: %0d grants seen, required 5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] != k % N) begin
        errors++;
        $display("FAIL fair_order: grant %0d went to LSU %0d, required %0d", k, got[k], k % N);
      end
    end
    for (int k = 1; k < cyc.size(); k++) begin
      checks++;
      if (cyc[k] - cyc[k-1] != 3) begin
        errors++;
        $display("FAIL fair_spacing: grant %0d after %0d cycles, required 3", k, cyc[k] - cyc[k-1]);
      end
    end
    wait_idle();
  endtask

  task automatic test_write_stall;
    @(posedge clk); #1;
    mem_write_req_rdy = 1'b0;
    lsu_write_req_addr[2*AW +: AW] = 8'h80;
    lsu_write_req_data[2*DW +: DW] = 16'h1234;
    lsu_write_req_val = 4'b0100;
    @(negedge clk);
    checks++;
    if (lsu_write_req_rdy !== 4'b0100 || lsu_read_req_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL wstall_accept: wrdy=%b rrdy=%b, required 0100 0000", lsu_write_req_rdy, lsu_read_req_rdy);
    end
    @(posedge clk); #1;
    lsu_write_req_val = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_write_req_val !== 1'b1 || mem_write_req_addr !== 8'h80 || mem_write_req_data !== 16'h1234 ||
          lsu_write_resp_val !== 4'b0000) begin
        errors++;
        $display("FAIL wstall_hold: cycle %0d wv=%b addr=%h data=%h resp=%b, required 1 80 1234 0000",
                 k, mem_write_req_val, mem_write_req_addr, mem_write_req_data, lsu_write_resp_val);
      end
    end
    @(posedge clk); #1;
    mem_write_req_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (lsu_write_resp_val !== 4'b0100 || mem_write_req_val !== 1'b0) begin
      errors++;
      $display("FAIL wstall_resp: resp=%b wv=%b, required 0100 0", lsu_write_resp_val, mem_write_req_val);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lsu_write_resp_val !== 4'b0000 || mem_arr[8'h80] !== 16'h1234) begin
      errors++;
      $display("FAIL wstall_done: busy=%b resp=%b mem=%h, required 0 0000 1234",
               busy, lsu_write_resp_val, mem_arr[8'h80]);
    end
  endtask

  // Entered with rr_ptr=3 (last grant was LSU2): LSU0 read, LSU1 read, then LSU0 write.
  task automatic test_rw_same;
    int got[$];
    int n = 0;
    logic [N-1:0] rv, wv;
    int exp_code[3] = '{0, 2, 1};
    lsu_read_req_addr[0*AW +: AW]  = 8'h10;
    lsu_read_req_addr[1*AW +: AW]  = 8'h20;
    lsu_write_req_addr[0*AW +: AW] = 8'h11;
    lsu_write_req_data[0*DW +: DW] = 16'hA5A5;
    @(posedge clk); #1;
    lsu_read_req_val  = 4'b0011;
    lsu_write_req_val = 4'b0001;
    while (got.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
      rv = lsu_read_req_rdy;
      wv = lsu_write_req_rdy;
      for (int i = 0; i < N; i++) begin
        if (rv[i]) got.push_back(i * 2);
        if (wv[i]) got.push_back(i * 2 + 1);
      end
      @(posedge clk); #1;
      lsu_read_req_val  = lsu_read_req_val & ~rv;
      lsu_write_req_val = lsu_write_req_val & ~wv;
    end
    lsu_read_req_val  = '0;
    lsu_write_req_val = '0;
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL rw_count: %0d grants seen, required 3", got.size());
    end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      checks++;
      if (got[k] != exp_code[k]) begin
        errors++;
        $display("FAIL rw_order: grant %0d lsu=%0d wr=%0d, required lsu=%0d wr=%0d",
                 k, got[k] / 2, got[k] % 2, exp_code[k] / 2, exp_code[k] % 2);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    auto_rresp = 1'b0;
    mem_read_resp_val = 1'b0;
    @(posedge clk); #1;
    lsu_read_req_addr[3*AW +: AW] = 8'h44;
    lsu_read_req_val = 4'b1000;
    @(negedge clk);
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || mem_read_req_val !== 1'b0) begin
      errors++;
      $display("FAIL rmid_wait: busy=%b g=%0d rv=%b, required 1 3 0", busy, grant_id, mem_read_req_val);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || mem_read_req_val !== 1'b0) begin
      errors++;
      $display("FAIL rmid_idle: busy=%b g=%0d rv=%b, required 0 0 0", busy, grant_id, mem_read_req_val);
    end
    @(posedge clk); #1;
    mem_read_resp_val  = 1'b1;
    mem_read_resp_data = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (lsu_read_resp_val !== 4'b0000 || mem_read_resp_rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_late_resp: rval=%b rrdy=%b busy=%b, required 0000 0 0",
               lsu_read_resp_val, mem_read_resp_rdy, busy);
    end
    @(posedge clk); #1;
    mem_read_resp_val = 1'b0;
    auto_rresp = 1'b1;
    lsu_read_req_val = 4'b0101;
    @(negedge clk);
    checks++;
    if (lsu_read_req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_ptr: rrdy=%b, required 0001", lsu_read_req_rdy);
    end
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    wait_idle();
  endtask

  task automatic test_resp_backpressure;
    mem_arr[8'h55] = 16'h7777;
    @(posedge clk); #1;
    lsu_read_resp_rdy[3] = 1'b0;
    lsu_read_req_addr[3*AW +: AW] = 8'h55;
    lsu_read_req_val = 4'b1000;
    @(negedge clk);
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_read_resp_rdy !== 1'b0 || busy !== 1'b1 || mem_read_resp_val !== 1'b1 ||
          lsu_read_resp_val !== 4'b1000) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d rrdy=%b busy=%b mval=%b lval=%b, required 0 1 1 1000",
                 k, mem_read_resp_rdy, busy, mem_read_resp_val, lsu_read_resp_val);
      end
    end
    @(posedge clk); #1;
    lsu_read_resp_rdy[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read_resp_rdy !== 1'b1 || lsu_read_resp_data !== 16'h7777) begin
      errors++;
      $display("FAIL bp_release: rrdy=%b data=%h, required 1 7777", mem_read_resp_rdy, lsu_read_resp_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc[$];
    int n = 0;
    lsu_read_req_addr[1*AW +: AW] = 8'h21;
    @(posedge clk); #1;
    lsu_read_req_val = 4'b0010;
    while (cyc.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (lsu_read_req_rdy == 4'b0010) cyc.push_back(n);
    end
    @(posedge clk); #1;
    lsu_read_req_val = '0;
    checks++;
    if (cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d grants seen, required 4", cyc.size());
    end
    for (int k = 1; k < cyc.size(); k++) begin
      checks++;
      if (cyc[k] - cyc[k-1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing: regrant %0d after %0d cycles, required 3", k, cyc[k] - cyc[k-1]);
      end
    end
    wait_idle();
  endtask

  initial begin
    reset = 1'b0;
    lsu_read_req_val = '0;  lsu_read_req_addr = '0;  lsu_read_resp_rdy = '1;
    lsu_write_req_val = '0; lsu_write_req_addr = '0; lsu_write_req_data = '0;
    mem_read_req_rdy = 1'b1; mem_write_req_rdy = 1'b1;
    mem_read_resp_val = 1'b0; mem_read_resp_data = '0; mem_write_resp_val = 1'b0;
    for (int a = 0; a < 256; a++) mem_arr[a] = 16'(16'hC000 + a);
    fork
      mem_model();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
      end
    join_none

    test_reset();
    test_single_read();
    test_fairness();
    test_write_stall();
    test_rw_same();
    test_reset_mid();
    test_resp_backpressure();
    test_back_to_back();

    checks++;
    if (req_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d requests and %0d responses outstanding, required 0 0", req_q.size(), resp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Round-robin arbiter sharing one data-memory port among `NUM_LSUS` load/store units in the minigpu compute core. Each LSU drives its normal read/write request channels into the arbiter as if it were memory. The arbiter grants one LSU at a time and forwards a single transaction to memory. It routes the response back to the granted LSU before re-arbitrating, so at most one memory transaction is outstanding at any time.

## Interface
Parameters:
- `NUM_LSUS`, 4: number of requesting LSUs; must be ≥2.
- `DATA_ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 16: memory data width.

Ports (per-LSU buses are flattened; LSU i occupies slice i):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `lsu_read_req_val`  in  NUM_LSUS  read request valid per LSU.
- `lsu_read_req_addr`  in  NUM_LSUS*DATA_ADDR_WIDTH  read addresses.
- `lsu_read_req_rdy`  out  NUM_LSUS  read request accepted.
- `lsu_read_resp_val`  out  NUM_LSUS  read data valid to the granted LSU.
- `lsu_read_resp_data`  out  DATA_WIDTH  read data, broadcast to all LSUs.
- `lsu_read_resp_rdy`  in  NUM_LSUS  LSU ready for read data.
- `lsu_write_req_val`  in  NUM_LSUS  write request valid.
- `lsu_write_req_addr`  in  NUM_LSUS*DATA_ADDR_WIDTH  write addresses.
- `lsu_write_req_data`  in  NUM_LSUS*DATA_WIDTH  write data.
- `lsu_write_req_rdy`  out  NUM_LSUS  write request accepted.
- `lsu_write_resp_val`  out  NUM_LSUS  write completed.
- `mem_read_req_val` / `mem_read_req_addr` / `mem_read_req_rdy`  out / out / in  1 / DATA_ADDR_WIDTH / 1  memory read request.
- `mem_read_resp_val` / `mem_read_resp_data` / `mem_read_resp_rdy`  in / in / out  1 / DATA_WIDTH / 1  memory read response.
- `mem_write_req_val` / `mem_write_req_addr` / `mem_write_req_data` / `mem_write_req_rdy`  out / out / out / in  1 / DATA_ADDR_WIDTH / DATA_WIDTH / 1  memory write request.
- `mem_write_resp_val`  in  1  memory write done.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  clog2(NUM_LSUS)  index of the current or last granted LSU.

## Operation
- FSM states: IDLE, READ_REQ, READ_WAIT, WRITE_REQ, WRITE_WAIT.
- **Arbitration (IDLE):**
  - LSU i is requesting if `lsu_read_req_val[i] | lsu_write_req_val[i]`.
  - The winner g is the first requester scanning upward from `rr_ptr` with wrap.
  - If g asserts both read and write valid, the read wins.
  - `lsu_read_req_rdy[g]` (or `lsu_write_req_rdy[g]`) is combinationally high in that cycle only; all other rdy bits are 0.
  - On that edge the arbiter latches g, the op, the address and (for writes) the data, then moves to READ_REQ or WRITE_REQ.
- **READ_REQ:** `mem_read_req_val`=1 with the latched address. On `mem_read_req_rdy`, go to READ_WAIT.
- **READ_WAIT:** pass-through routing:
  - `lsu_read_resp_val[g]` = `mem_read_resp_val`
  - `lsu_read_resp_data` = `mem_read_resp_data`
  - `mem_read_resp_rdy` = `lsu_read_resp_rdy[g]`
  - When both valid and rdy are high, go to IDLE.
- **WRITE_REQ:** `mem_write_req_val`=1 with the latched address and data. On `mem_write_req_rdy`, go to WRITE_WAIT.
- **WRITE_WAIT:** `lsu_write_resp_val[g]` = `mem_write_resp_val`. On `mem_write_resp_val`, go to IDLE.
- **Round-robin pointer:** on every return to IDLE, `rr_ptr` = (g == NUM_LSUS-1) ? 0 : g+1. No other event changes `rr_ptr`.
- **Ignored inputs:**
  - `mem_read_resp_val` is ignored outside READ_WAIT.
  - `mem_write_resp_val` is ignored outside WRITE_WAIT.
  - LSU valid signals are ignored outside IDLE.
- All `lsu_*_rdy` and `lsu_*_resp_val` bits for non-granted LSUs are 0 in every state.

## Timing
- **Reset** (`reset`==0 at a rising edge), including mid-transaction:
  - State returns to IDLE; `rr_ptr` and `grant_id` become 0; latched address/data are cleared.
  - All outputs are low while in IDLE with no requests.
  - An in-flight memory transaction is abandoned; the memory is reset on the same signal.
- **Output types:**
  - `busy`, `grant_id` and all `mem_*_req_*` signals are registered, driven from state.
  - `lsu_*_rdy`, resp pass-throughs and `mem_read_resp_rdy` are combinational from state, g and the inputs.
- **Minimum latency** with memory always ready and responding in the same cycle:
  - Read: accept (cycle 0) → READ_REQ (cycle 1) → READ_WAIT with response (cycle 2) → IDLE (cycle 3).
  - Write: same four cycles.
  - Next grant is possible in cycle 3.
- **Back-pressure:** a stalled memory or LSU holds the FSM in its current state indefinitely. Request fields stay stable.
- **Single requester:** one LSU requesting continuously is re-granted every 3 cycles.

## Test plan
- **Single read:** LSU1 reads addr 0x3C; memory returns 0xBEEF one cycle after the request.
  - → `lsu_read_resp_val`=4'b0010 with data 0xBEEF.
  - → `grant_id`=1; `rr_ptr`=2 afterwards.
- **Fairness:** all 4 LSUs hold read valid from reset.
  - → grants occur in order 0,1,2,3,0.
  - → no LSU is granted twice before the others are served.
- **Write with stall:** LSU2 writes 0x1234 to addr 0x80; `mem_write_req_rdy` is held low 5 cycles.
  - → `mem_write_req_val`/addr/data stay stable for those 5 cycles.
  - → `lsu_write_resp_val[2]` pulses on `mem_write_resp_val`.
- **Simultaneous read and write:** LSU0 asserts read and write in the same cycle.
  - → the read is served first.
  - → the write is served on a later grant once the pointer wraps back to LSU0.
- **Reset mid-transaction:** `reset` is pulled low while in READ_WAIT.
  - → next cycle is IDLE, `busy`=0, `grant_id`=0.
  - → a late `mem_read_resp_val` produces no `lsu_read_resp_val`.
- **Response back-pressure:** `lsu_read_resp_rdy[3]`=0 for 3 cycles while memory data is valid.
  - → `mem_read_resp_rdy`=0 for those cycles; the FSM stays in READ_WAIT.
  - → completes on the first cycle rdy rises.
